// File: rtl/calc1_engine_if.sv
// One calculator request/response port: command and operands in, response code and result out.
interface calc1_engine_if;
    logic [3:0]  cmd_in;
    logic [31:0] data_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;

    modport master (output cmd_in, data_in, input out_resp, out_data);
    modport slave  (input cmd_in, data_in, output out_resp, out_data);
endinterface

// File: rtl/calc1_engine.sv
// Four independent 32-bit unsigned calculator ports (add, subtract, optional shifts).
// Define CALC1_SHIFT_EN to build the shifter; otherwise commands 5 and 6 answer as invalid.

// state | meaning
// IDLE  | waiting for a non-zero command with operand1
// OP2   | capturing operand2; command input ignored
// EXEC  | result registered this edge; a new command may be accepted simultaneously
module calc1_port (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cmd_in,
    input  logic [31:0] data_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data
);
    typedef enum logic [1:0] {IDLE, OP2, EXEC} state_t;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
`ifdef CALC1_SHIFT_EN
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;
`endif
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    state_t      state;
    logic [3:0]  cmd_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [32:0] sum;
    logic        res_ok;
    logic [31:0] res_val;

    always_comb begin
        sum     = {1'b0, op1_q} + {1'b0, op2_q};
        res_ok  = 1'b0;
        res_val = '0;
        case (cmd_q)
            CMD_ADD: if (!sum[32]) begin
                res_ok  = 1'b1;
                res_val = sum[31:0];
            end
            CMD_SUB: if (op2_q <= op1_q) begin
                res_ok  = 1'b1;
                res_val = op1_q - op2_q;
            end
`ifdef CALC1_SHIFT_EN
            // Only the low five bits of operand2 form the shift amount.
            CMD_SHL: begin
                res_ok  = 1'b1;
                res_val = op1_q << op2_q[4:0];
            end
            CMD_SHR: begin
                res_ok  = 1'b1;
                res_val = op1_q >> op2_q[4:0];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cmd_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            out_resp <= RESP_NONE;
            out_data <= '0;
        end else begin
            out_resp <= RESP_NONE;
            out_data <= '0;
            case (state)
                IDLE: if (cmd_in != 4'd0) begin
                    cmd_q <= cmd_in;
                    op1_q <= data_in;
                    state <= OP2;
                end
                OP2: begin
                    op2_q <= data_in;
                    state <= EXEC;
                end
                EXEC: begin
                    out_resp <= res_ok ? RESP_OK : RESP_ERR;
                    out_data <= res_val;
                    if (cmd_in != 4'd0) begin
                        cmd_q <= cmd_in;
                        op1_q <= data_in;
                        state <= OP2;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module calc1_engine (
    input  logic          c_clk,
    input  logic          reset,
    calc1_engine_if.slave req1,
    calc1_engine_if.slave req2,
    calc1_engine_if.slave req3,
    calc1_engine_if.slave req4
);
    calc1_port u_port1 (
        .clk(c_clk), .reset(reset),
        .cmd_in(req1.cmd_in), .data_in(req1.data_in),
        .out_resp(req1.out_resp), .out_data(req1.out_data)
    );
    calc1_port u_port2 (
        .clk(c_clk), .reset(reset),
        .cmd_in(req2.cmd_in), .data_in(req2.data_in),
        .out_resp(req2.out_resp), .out_data(req2.out_data)
    );
    calc1_port u_port3 (
        .clk(c_clk), .reset(reset),
        .cmd_in(req3.cmd_in), .data_in(req3.data_in),
        .out_resp(req3.out_resp), .out_data(req3.out_data)
    );
    calc1_port u_port4 (
        .clk(c_clk), .reset(reset),
        .cmd_in(req4.cmd_in), .data_in(req4.data_in),
        .out_resp(req4.out_resp), .out_data(req4.out_data)
    );
endmodule

// File: tb/tb_calc1_engine.sv
// Directed self-checking bench for calc1_engine; inputs driven and outputs sampled on falling edges.
module tb_calc1_engine;
    logic c_clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    calc1_engine_if p1 ();
    calc1_engine_if p2 ();
    calc1_engine_if p3 ();
    calc1_engine_if p4 ();

    calc1_engine dut (
        .c_clk(c_clk), .reset(reset),
        .req1(p1), .req2(p2), .req3(p3), .req4(p4)
    );

    always #5 c_clk = ~c_clk;

    task automatic idle_all();
        p1.cmd_in = 4'd0; p1.data_in = '0;
        p2.cmd_in = 4'd0; p2.data_in = '0;
        p3.cmd_in = 4'd0; p3.data_in = '0;
        p4.cmd_in = 4'd0; p4.data_in = '0;
    endtask

    // Single transaction on port 1; returns the response seen in the cycle after EXEC.
    task automatic txn1(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        output logic [1:0] r, output logic [31:0] d);
        @(negedge c_clk); p1.cmd_in = cmd;   p1.data_in = a;
        @(negedge c_clk); p1.cmd_in = 4'hF;  p1.data_in = b;
        @(negedge c_clk); p1.cmd_in = 4'd0;  p1.data_in = '0;
        @(negedge c_clk); r = p1.out_resp;   d = p1.out_data;
    endtask

    task automatic test_reset();
        logic [135:0] obs;
        reset = 1'b0;
        idle_all();
        repeat (3) @(negedge c_clk);
        obs = {p1.out_resp, p1.out_data, p2.out_resp, p2.out_data,
               p3.out_resp, p3.out_data, p4.out_resp, p4.out_data};
        n_total++;
        if (obs !== 136'd0) $display("FAIL reset_outputs got=%h exp=0", obs);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_add();
        logic [31:0] a  [4] = '{32'h0000_0001, 32'h1FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        logic [31:0] b  [4] = '{32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        logic [1:0]  er [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        logic [31:0] ed [4] = '{32'h2000_0000, 32'h3FFF_FFFE, 32'h0, 32'h0};
        logic [1:0]  r;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            txn1(4'd1, a[i], b[i], r, d);
            n_total++;
            if ({r, d} !== {er[i], ed[i]})
                $display("FAIL add[%0d] resp=%b data=%h exp resp=%b data=%h", i, r, d, er[i], ed[i]);
            else n_pass++;
            if (i == 0) begin
                @(negedge c_clk);
                n_total++;
                if ({p1.out_resp, p1.out_data} !== 34'd0)
                    $display("FAIL resp_one_cycle resp=%b data=%h exp 00/0", p1.out_resp, p1.out_data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sub();
        logic [1:0]  r;
        logic [31:0] d;
        txn1(4'd2, 32'h1, 32'hF, r, d);
        n_total++;
        if ({r, d} !== {2'b10, 32'h0}) $display("FAIL sub_under resp=%b data=%h exp 10/0", r, d);
        else n_pass++;
        txn1(4'd2, 32'hF, 32'h1, r, d);
        n_total++;
        if ({r, d} !== {2'b01, 32'hE}) $display("FAIL sub_ok resp=%b data=%h exp 01/e", r, d);
        else n_pass++;
    endtask

    task automatic test_invalid();
        logic [3:0]  cmds [3] = '{4'd3, 4'd4, 4'd15};
        logic [1:0]  r;
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            txn1(cmds[i], 32'h1234_5678, 32'h0000_0002, r, d);
            n_total++;
            if ({r, d} !== {2'b10, 32'h0})
                $display("FAIL invalid_cmd%0d resp=%b data=%h exp 10/0", cmds[i], r, d);
            else n_pass++;
        end
    endtask

    task automatic test_noop();
        logic seen = 1'b0;
        @(negedge c_clk); p1.cmd_in = 4'd0; p1.data_in = 32'hDEAD_BEEF;
        @(negedge c_clk); p1.data_in = 32'h0000_0005;
        @(negedge c_clk); p1.data_in = '0;
        repeat (4) begin
            @(negedge c_clk);
            if (p1.out_resp !== 2'b00) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL noop got response exp none");
        else n_pass++;
    endtask

    task automatic test_sweep();
        logic [1:0]  r;
        logic [31:0] d;
        int          bad = 0;
        for (int i = 0; i < 15; i++) begin
            txn1(4'd1, 32'd1 << i, 32'h0, r, d);
            n_total++;
            if ({r, d} !== {2'b01, 32'd1 << i}) begin
                $display("FAIL sweep x=%h resp=%b data=%h exp 01/%h", 32'd1 << i, r, d, 32'd1 << i);
                bad++;
            end else n_pass++;
        end
    endtask

    task automatic test_parallel();
        @(negedge c_clk);
        p1.cmd_in = 4'd1; p1.data_in = 32'd5;
        p2.cmd_in = 4'd2; p2.data_in = 32'd10;
        p3.cmd_in = 4'd9; p3.data_in = 32'd77;
        p4.cmd_in = 4'd2; p4.data_in = 32'd3;
        @(negedge c_clk);
        p1.cmd_in = 4'd0; p1.data_in = 32'd7;
        p2.cmd_in = 4'd0; p2.data_in = 32'd3;
        p3.cmd_in = 4'd0; p3.data_in = 32'd1;
        p4.cmd_in = 4'd0; p4.data_in = 32'd10;
        @(negedge c_clk); idle_all();
        @(negedge c_clk);
        n_total++;
        if ({p1.out_resp, p1.out_data} !== {2'b01, 32'd12})
            $display("FAIL par_p1 resp=%b data=%h exp 01/c", p1.out_resp, p1.out_data);
        else n_pass++;
        n_total++;
        if ({p2.out_resp, p2.out_data} !== {2'b01, 32'd7})
            $display("FAIL par_p2 resp=%b data=%h exp 01/7", p2.out_resp, p2.out_data);
        else n_pass++;
        n_total++;
        if ({p3.out_resp, p3.out_data} !== {2'b10, 32'd0})
            $display("FAIL par_p3 resp=%b data=%h exp 10/0", p3.out_resp, p3.out_data);
        else n_pass++;
        n_total++;
        if ({p4.out_resp, p4.out_data} !== {2'b10, 32'd0})
            $display("FAIL par_p4 resp=%b data=%h exp 10/0", p4.out_resp, p4.out_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge c_clk); p2.cmd_in = 4'd1; p2.data_in = 32'd100;
        @(negedge c_clk); p2.cmd_in = 4'd0; p2.data_in = 32'd23;
        @(negedge c_clk); p2.cmd_in = 4'd2; p2.data_in = 32'd50;
        @(negedge c_clk);
        n_total++;
        if ({p2.out_resp, p2.out_data} !== {2'b01, 32'd123})
            $display("FAIL b2b_first resp=%b data=%h exp 01/7b", p2.out_resp, p2.out_data);
        else n_pass++;
        p2.cmd_in = 4'd0; p2.data_in = 32'd8;
        @(negedge c_clk); p2.data_in = '0;
        @(negedge c_clk);
        n_total++;
        if ({p2.out_resp, p2.out_data} !== {2'b01, 32'd42})
            $display("FAIL b2b_second resp=%b data=%h exp 01/2a", p2.out_resp, p2.out_data);
        else n_pass++;
    endtask

    task automatic test_shift();
        logic [1:0]  r;
        logic [31:0] d;
        logic [33:0] exp_l;
        logic [33:0] exp_r;
`ifdef CALC1_SHIFT_EN
        exp_l = {2'b01, 32'h0000_0010};
        exp_r = {2'b01, 32'h4000_0000};
`else
        exp_l = {2'b10, 32'h0};
        exp_r = {2'b10, 32'h0};
`endif
        txn1(4'd5, 32'h1, 32'h0000_0024, r, d);
        n_total++;
        if ({r, d} !== exp_l) $display("FAIL shl resp=%b data=%h exp %h", r, d, exp_l);
        else n_pass++;
        txn1(4'd6, 32'h8000_0000, 32'hFFFF_FFE1, r, d);
        n_total++;
        if ({r, d} !== exp_r) $display("FAIL shr resp=%b data=%h exp %h", r, d, exp_r);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        @(negedge c_clk); p1.cmd_in = 4'd5; p1.data_in = 32'h1;
        @(negedge c_clk); p1.cmd_in = 4'd0; p1.data_in = 32'h24; reset = 1'b0;
        @(negedge c_clk); reset = 1'b1; p1.data_in = '0;
        repeat (3) begin
            @(negedge c_clk);
            if ({p1.out_resp, p1.out_data} !== 34'd0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL reset_in_op2 response leaked exp 00/0");
        else n_pass++;

        seen = 1'b0;
        @(negedge c_clk); p1.cmd_in = 4'd1; p1.data_in = 32'h3;
        @(negedge c_clk); p1.cmd_in = 4'd0; p1.data_in = 32'h4;
        @(negedge c_clk); p1.data_in = '0; reset = 1'b0;
        @(negedge c_clk); reset = 1'b1;
        if ({p1.out_resp, p1.out_data} !== 34'd0) seen = 1'b1;
        repeat (2) begin
            @(negedge c_clk);
            if ({p1.out_resp, p1.out_data} !== 34'd0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL reset_in_exec response leaked exp 00/0");
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_invalid();
        test_noop();
        test_sweep();
        test_parallel();
        test_back_to_back();
        test_shift();
        test_reset_mid();
        repeat (2) @(negedge c_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
